uart_cmd_parser: RTL

- Sits directly downstream of the UART receiver and consumes its byte stream (data/valid pulse plus framing-error pulse).
- Assembles framed host commands: SYNC, OPCODE, LEN, LEN payload bytes, CHECKSUM.
- Validates each frame and presents it as one held command on a valid/ready interface to the TPU control logic.
- Rejects bad frames with single-cycle error pulses.

---
 rtl/uart_cmd_parser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Turns the UART receiver byte stream into framed host commands:
//    SYNC, OPCODE, LEN, LEN payload bytes, CHECKSUM (XOR of OPCODE, LEN and
//    the payload bytes). A good frame is held on a valid/ready interface
//    until it is accepted. A bad frame produces a single-cycle error pulse.
//
// Handshake: cmd_valid rises one clock after the checksum byte and stays
//    high, with cmd_opcode/cmd_len/cmd_payload stable, until the first
//    cycle in which cmd_valid && cmd_ready. It drops on the next cycle.
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    rx_data, rx_valid   received byte and its one-cycle strobe
//    rx_framing_error    one-cycle strobe for a bad stop bit
//    cmd_valid/ready     command handshake
//    cmd_opcode          opcode of the held command
//    cmd_len             payload byte count of the held command
//    cmd_payload         payload, byte i at [8i+7:8i], unused bytes 0
//    err_checksum        checksum mismatch pulse
//    err_length          LEN > MAX_LEN pulse
//    err_timeout         inter-byte timeout pulse
//    err_overrun         byte dropped while a command is held
//    busy                high whenever the parser is not idle
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 104160,
   parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   input  logic                   rx_framing_error,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [7:0]             cmd_opcode,
   output logic [LEN_W-1:0]       cmd_len,
   output logic [MAX_LEN*8-1:0]   cmd_payload,
   output logic                   err_checksum,
   output logic                   err_length,
   output logic                   err_timeout,
   output logic                   err_overrun,
   output logic                   busy
);

   localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_OPCODE  = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CHECK   = 3'd4,
      S_HOLD    = 3'd5
   } state_e;

   state_e                 state_q,   state_d;
   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic [7:0]             csum_q,    csum_d;
   logic [LEN_W-1:0]       idx_q,     idx_d;
   logic [7:0]             opcode_q,  opcode_d;
   logic [LEN_W-1:0]       len_q,     len_d;
   logic [MAX_LEN*8-1:0]   payload_q, payload_d;
   logic                   err_cks_q, err_cks_d;
   logic                   err_len_q, err_len_d;
   logic                   err_to_q,  err_to_d;
   logic                   err_ovr_q, err_ovr_d;

   logic in_frame;
   assign in_frame = (state_q == S_OPCODE) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHECK);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         csum_q    <= '0;
         idx_q     <= '0;
         opcode_q  <= '0;
         len_q     <= '0;
         payload_q <= '0;
         err_cks_q <= 1'b0;
         err_len_q <= 1'b0;
         err_to_q  <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         idx_q     <= idx_d;
         opcode_q  <= opcode_d;
         len_q     <= len_d;
         payload_q <= payload_d;
         err_cks_q <= err_cks_d;
         err_len_q <= err_len_d;
         err_to_q  <= err_to_d;
         err_ovr_q <= err_ovr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      idx_d     = idx_q;
      opcode_d  = opcode_q;
      len_d     = len_q;
      payload_d = payload_q;
      err_cks_d = 1'b0;
      err_len_d = 1'b0;
      err_to_d  = 1'b0;
      err_ovr_d = 1'b0;

      if (in_frame) begin
         // Priority inside a frame: framing error, then a byte, then timeout.
         // A byte arriving in the expiry cycle therefore still counts.
         if (rx_framing_error) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
               S_OPCODE: begin
                  opcode_d = rx_data;
                  csum_d   = rx_data;
                  state_d  = S_LEN;
               end
               S_LEN: begin
                  csum_d = csum_q ^ rx_data;
                  idx_d  = '0;
                  if (rx_data > 8'(MAX_LEN)) begin
                     err_len_d = 1'b1;
                     state_d   = S_IDLE;
                  end else begin
                     len_d   = rx_data[LEN_W-1:0];
                     state_d = (rx_data == 8'd0) ? S_CHECK : S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  csum_d = csum_q ^ rx_data;
                  for (int i = 0; i < int'(MAX_LEN); i++) begin
                     if (idx_q == LEN_W'(i)) payload_d[i*8 +: 8] = rx_data;
                  end
                  idx_d = idx_q + LEN_W'(1);
                  if (idx_q + LEN_W'(1) == len_q) state_d = S_CHECK;
               end
               default: begin // S_CHECK
                  if (rx_data == csum_q) begin
                     state_d = S_HOLD;
                  end else begin
                     err_cks_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
            endcase
         end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
            err_to_d = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (state_q == S_HOLD) begin
         // The held command is never disturbed; incoming bytes are lost.
         err_ovr_d = rx_valid;
         if (cmd_ready) state_d = S_IDLE;
      end else begin // S_IDLE
         if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_d   = S_OPCODE;
            payload_d = '0;
            csum_d    = '0;
            cnt_d     = '0;
            idx_d     = '0;
         end
      end
   end

   // Outputs
   always_comb begin
      cmd_valid    = (state_q == S_HOLD);
      busy         = (state_q != S_IDLE);
      cmd_opcode   = opcode_q;
      cmd_len      = len_q;
      cmd_payload  = payload_q;
      err_checksum = err_cks_q;
      err_length   = err_len_q;
      err_timeout  = err_to_q;
      err_overrun  = err_ovr_q;
   end

endmodule
